// File: rtl/jk_reg_bank_pkg.sv
// -----------------------------------------------------------------------------
// jk_reg_bank_pkg
//   Shared definitions for the JK register bank family.
//   The mode encodings are common to this block, to the future counter and
//   shifter blocks built on it, and to the testbench.
// -----------------------------------------------------------------------------
package jk_reg_bank_pkg;

  localparam int MODE_W = 3;

  typedef logic [MODE_W-1:0] mode_t;

  // Operation select. Encodings 6 and 7 are reserved and behave as HOLD.
  localparam mode_t MODE_HOLD = 3'd0;
  localparam mode_t MODE_JK   = 3'd1;
  localparam mode_t MODE_LOAD = 3'd2;
  localparam mode_t MODE_UP   = 3'd3;
  localparam mode_t MODE_DOWN = 3'd4;
  localparam mode_t MODE_SHL  = 3'd5;

endpackage : jk_reg_bank_pkg

// File: rtl/jk_reg_bank_if.sv
// -----------------------------------------------------------------------------
// jk_reg_bank_if
//   Control/data bundle of the JK register bank.
//   master : drives en, mode, j, k, d, sin; observes q, q_n, tc
//   slave  : the register bank itself (inverse directions)
//   Signals:
//     en    clock enable, 0 = hold
//     mode  operation select (MODE_* in jk_reg_bank_pkg)
//     j, k  per-bit JK inputs, used in MODE_JK only
//     d     parallel load data, used in MODE_LOAD only
//     sin   serial input into bit 0, used in MODE_SHL only
//     q     register state
//     q_n   ~q
//     tc    terminal count for UP/DOWN
// -----------------------------------------------------------------------------
interface jk_reg_bank_if #(
  parameter int WIDTH = 8
);
  import jk_reg_bank_pkg::*;

  logic             en;
  mode_t            mode;
  logic [WIDTH-1:0] j;
  logic [WIDTH-1:0] k;
  logic [WIDTH-1:0] d;
  logic             sin;
  logic [WIDTH-1:0] q;
  logic [WIDTH-1:0] q_n;
  logic             tc;

  modport master (
    output en, mode, j, k, d, sin,
    input  q, q_n, tc
  );

  modport slave (
    input  en, mode, j, k, d, sin,
    output q, q_n, tc
  );

endinterface : jk_reg_bank_if

// File: rtl/jk_cell.sv
// -----------------------------------------------------------------------------
// jk_cell
//   Single JK flip-flop with synchronous active-high reset and clock enable.
//   Ports:
//     clk     rising-edge clock
//     reset   synchronous active-high reset, loads init_i
//     en_i    clock enable, 0 = hold
//     j_i     J input
//     k_i     K input
//     init_i  reset value
//     q_o     flop state
//   JK truth table (j,k): 00 hold, 01 clear, 10 set, 11 toggle.
// -----------------------------------------------------------------------------
module jk_cell (
  input  logic clk,
  input  logic reset,
  input  logic en_i,
  input  logic j_i,
  input  logic k_i,
  input  logic init_i,
  output logic q_o
);

  logic q_q;
  logic q_d;

  // Characteristic equation of the JK flop; the only next-state path.
  assign q_d = (j_i & ~q_q) | (~k_i & q_q);

  // NOTE: sequential state uses non-blocking assignments so every cell in the
  // bank samples the pre-edge value of its neighbours (needed for SHL/UP/DOWN).
  always_ff @(posedge clk) begin
    if (reset) begin
      q_q <= init_i;
    end else if (en_i) begin
      q_q <= q_d;
    end
  end

  assign q_o = q_q;

endmodule : jk_cell

// File: rtl/jk_reg_bank.sv
// -----------------------------------------------------------------------------
// jk_reg_bank
//   WIDTH-bit register built from WIDTH jk_cell instances. Every operation is
//   realised by steering the per-cell J/K inputs; there is no direct D path.
//   Ports:
//     clk     rising-edge clock
//     reset   synchronous active-high reset, q <= RESET_VAL (beats en/mode)
//     bus     jk_reg_bank_if.slave : en, mode, j, k, d, sin in; q, q_n, tc out
//   Modes (jk_reg_bank_pkg):
//     HOLD  q unchanged          JK    per-bit JK update
//     LOAD  q <= d               UP    q <= q + 1 (wraps)
//     DOWN  q <= q - 1 (wraps)   SHL   q <= {q[WIDTH-2:0], sin}
//     6, 7  reserved, hold
//   tc is high while enabled, out of reset, and the next UP/DOWN edge wraps.
// -----------------------------------------------------------------------------
module jk_reg_bank
  import jk_reg_bank_pkg::*;
#(
  parameter int               WIDTH     = 8,
  parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
  input  logic          clk,
  input  logic          reset,
  jk_reg_bank_if.slave  bus
);

  // Current state gathered from the cells.
  logic [WIDTH-1:0] q_bits;

  // Per-cell drive.
  logic [WIDTH-1:0] cell_j;
  logic [WIDTH-1:0] cell_k;

  // Toggle masks for counting: bit i toggles when all lower bits are 1 (UP)
  // or all lower bits are 0 (DOWN). Bit 0 toggles unconditionally.
  logic [WIDTH-1:0] up_t;
  logic [WIDTH-1:0] dn_t;

  // Target value for the left shift; driven as J=b, K=~b to force it.
  logic [WIDTH-1:0] shl_v;

  assign up_t[0] = 1'b1;
  assign dn_t[0] = 1'b1;

  for (genvar i = 1; i < WIDTH; i++) begin : g_toggle
    assign up_t[i] =  (&q_bits[i-1:0]);
    assign dn_t[i] = ~(|q_bits[i-1:0]);
  end

  assign shl_v = {q_bits[WIDTH-2:0], bus.sin};

  // Mode decode. Toggle is J=K=1, forcing a value is J=v, K=~v, hold is J=K=0.
  // NOTE: both outputs get a default before the case, so no mode (including
  // the reserved encodings) can leave them unassigned and infer a latch.
  always_comb begin
    cell_j = '0;
    cell_k = '0;
    unique case (bus.mode)
      MODE_JK: begin
        cell_j = bus.j;
        cell_k = bus.k;
      end
      MODE_LOAD: begin
        cell_j =  bus.d;
        cell_k = ~bus.d;
      end
      MODE_UP: begin
        cell_j = up_t;
        cell_k = up_t;
      end
      MODE_DOWN: begin
        cell_j = dn_t;
        cell_k = dn_t;
      end
      MODE_SHL: begin
        cell_j =  shl_v;
        cell_k = ~shl_v;
      end
      default: begin
        // MODE_HOLD and reserved encodings keep J=K=0.
      end
    endcase
  end

  for (genvar i = 0; i < WIDTH; i++) begin : g_cell
    jk_cell u_cell (
      .clk    (clk),
      .reset  (reset),
      .en_i   (bus.en),
      .j_i    (cell_j[i]),
      .k_i    (cell_k[i]),
      .init_i (RESET_VAL[i]),
      .q_o    (q_bits[i])
    );
  end

  assign bus.q   = q_bits;
  assign bus.q_n = ~q_bits;

  // Terminal count flags the wrap about to happen on the next enabled edge;
  // it is masked while reset is asserted because that edge reloads instead.
  assign bus.tc = ~reset & bus.en &
                  (((bus.mode == MODE_UP)   &  (&q_bits)) |
                   ((bus.mode == MODE_DOWN) & ~(|q_bits)));

endmodule : jk_reg_bank

// File: tb/tb_jk_reg_bank.sv
// -----------------------------------------------------------------------------
// tb_jk_reg_bank
//   Two 4-bit banks (RESET_VAL 0000 and 1010) driven with identical stimulus,
//   compared every cycle against an arithmetic reference model, plus directed
//   expectations for the documented scenarios.
// -----------------------------------------------------------------------------
module tb_jk_reg_bank;
  import jk_reg_bank_pkg::*;

  localparam int         W   = 4;
  localparam logic [3:0] RV0 = 4'b0000;
  localparam logic [3:0] RV1 = 4'b1010;

  logic clk = 1'b0;
  logic reset;

  int checks   = 0;
  int failures = 0;

  logic [3:0] m0;      // model state, bank 0
  logic [3:0] m1;      // model state, bank 1
  logic       tc_seen; // pre-edge tc of bank 0 from the latest step

  jk_reg_bank_if #(.WIDTH(W)) bus0 ();
  jk_reg_bank_if #(.WIDTH(W)) bus1 ();

  jk_reg_bank #(.WIDTH(W), .RESET_VAL(RV0)) dut0 (
    .clk   (clk),
    .reset (reset),
    .bus   (bus0)
  );

  jk_reg_bank #(.WIDTH(W), .RESET_VAL(RV1)) dut1 (
    .clk   (clk),
    .reset (reset),
    .bus   (bus1)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  // Reference next state from the behavioural rules.
  function automatic logic [3:0] model_next(input logic [3:0] cur, input logic [3:0] rv,
                                            input logic r, input logic e, input mode_t md,
                                            input logic [3:0] jj, input logic [3:0] kk,
                                            input logic [3:0] dd, input logic s);
    logic [3:0] nx;
    if (r)  return rv;
    if (!e) return cur;
    nx = cur;
    case (md)
      MODE_JK: begin
        for (int i = 0; i < 4; i++) begin
          case ({jj[i], kk[i]})
            2'b01:   nx[i] = 1'b0;
            2'b10:   nx[i] = 1'b1;
            2'b11:   nx[i] = ~cur[i];
            default: nx[i] = cur[i];
          endcase
        end
      end
      MODE_LOAD: nx = dd;
      MODE_UP:   nx = cur + 4'd1;
      MODE_DOWN: nx = cur - 4'd1;
      MODE_SHL:  nx = {cur[2:0], s};
      default:   nx = cur;
    endcase
    return nx;
  endfunction

  function automatic logic model_tc(input logic [3:0] cur, input logic r, input logic e,
                                    input mode_t md);
    return !r && e && ((md == MODE_UP && cur == 4'hF) || (md == MODE_DOWN && cur == 4'h0));
  endfunction

  // Drive one cycle of stimulus, check combinational outputs before the edge
  // and the registered state just after it.
  task automatic step(input logic r, input logic e, input mode_t md,
                      input logic [3:0] jj, input logic [3:0] kk,
                      input logic [3:0] dd, input logic s);
    @(negedge clk);
    reset     = r;
    bus0.en   = e;  bus1.en   = e;
    bus0.mode = md; bus1.mode = md;
    bus0.j    = jj; bus1.j    = jj;
    bus0.k    = kk; bus1.k    = kk;
    bus0.d    = dd; bus1.d    = dd;
    bus0.sin  = s;  bus1.sin  = s;
    #1;
    tc_seen = bus0.tc;
    check("tc0",  {31'd0, bus0.tc}, {31'd0, model_tc(m0, r, e, md)});
    check("tc1",  {31'd0, bus1.tc}, {31'd0, model_tc(m1, r, e, md)});
    check("qn0",  {28'd0, bus0.q_n}, {28'd0, ~m0});
    m0 = model_next(m0, RV0, r, e, md, jj, kk, dd, s);
    m1 = model_next(m1, RV1, r, e, md, jj, kk, dd, s);
    @(posedge clk);
    #1;
    check("q0", {28'd0, bus0.q}, {28'd0, m0});
    check("q1", {28'd0, bus1.q}, {28'd0, m1});
  endtask

  initial begin
    m0 = 4'hx;
    m1 = 4'hx;
    reset = 1'b1;
    bus0.en = 1'b0; bus0.mode = MODE_HOLD; bus0.j = '0; bus0.k = '0; bus0.d = '0; bus0.sin = 1'b0;
    bus1.en = 1'b0; bus1.mode = MODE_HOLD; bus1.j = '0; bus1.k = '0; bus1.d = '0; bus1.sin = 1'b0;

    // Reset: two edges with arbitrary en/mode; the model is defined after the
    // first one, so the very first step only checks after the edge.
    @(negedge clk);
    reset = 1'b1; bus0.en = 1'b1; bus1.en = 1'b1;
    bus0.mode = MODE_UP; bus1.mode = MODE_UP;
    #1;
    check("rst_tc", {31'd0, bus0.tc}, 32'd0);
    @(posedge clk); #1;
    m0 = RV0; m1 = RV1;
    step(1'b1, 1'b0, MODE_LOAD, 4'h0, 4'h0, 4'hF, 1'b1);
    check("rst_q_rv0",  {28'd0, bus0.q},   32'h0);
    check("rst_qn_rv0", {28'd0, bus0.q_n}, 32'hF);
    check("rst_q_rv1",  {28'd0, bus1.q},   32'hA);
    check("rst_qn_rv1", {28'd0, bus1.q_n}, 32'h5);

    // JK set/clear, toggle, hold.
    step(1'b0, 1'b1, MODE_JK, 4'b1100, 4'b0011, 4'h0, 1'b0);
    check("jk_setclr", {28'd0, bus0.q}, 32'b1100);
    step(1'b0, 1'b1, MODE_JK, 4'b1111, 4'b1111, 4'h0, 1'b0);
    check("jk_toggle", {28'd0, bus0.q}, 32'b0011);
    step(1'b0, 1'b1, MODE_JK, 4'b0000, 4'b0000, 4'hF, 1'b1);
    check("jk_hold", {28'd0, bus0.q}, 32'b0011);

    // Load then count up through the wrap, then down through the wrap.
    step(1'b0, 1'b1, MODE_LOAD, 4'hF, 4'hF, 4'b1110, 1'b0);
    check("load", {28'd0, bus0.q}, 32'b1110);
    step(1'b0, 1'b1, MODE_UP, 4'h0, 4'h0, 4'h0, 1'b0);
    check("up_1111", {28'd0, bus0.q}, 32'b1111);
    step(1'b0, 1'b1, MODE_UP, 4'h0, 4'h0, 4'h0, 1'b0);
    check("up_tc", {31'd0, tc_seen}, 32'd1);
    check("up_wrap", {28'd0, bus0.q}, 32'b0000);
    step(1'b0, 1'b1, MODE_UP, 4'h0, 4'h0, 4'h0, 1'b0);
    check("up_0001", {28'd0, bus0.q}, 32'b0001);
    step(1'b0, 1'b1, MODE_DOWN, 4'h0, 4'h0, 4'h0, 1'b0);
    check("down_0000", {28'd0, bus0.q}, 32'b0000);
    step(1'b0, 1'b1, MODE_DOWN, 4'h0, 4'h0, 4'h0, 1'b0);
    check("down_tc", {31'd0, tc_seen}, 32'd1);
    check("down_wrap", {28'd0, bus0.q}, 32'b1111);

    // Shift left from zero, then disable.
    step(1'b1, 1'b1, MODE_HOLD, 4'h0, 4'h0, 4'h0, 1'b0);
    step(1'b0, 1'b1, MODE_SHL, 4'hF, 4'h0, 4'hF, 1'b1);
    check("shl_0001", {28'd0, bus0.q}, 32'b0001);
    step(1'b0, 1'b1, MODE_SHL, 4'hF, 4'h0, 4'hF, 1'b0);
    check("shl_0010", {28'd0, bus0.q}, 32'b0010);
    step(1'b0, 1'b1, MODE_SHL, 4'hF, 4'h0, 4'hF, 1'b1);
    check("shl_0101", {28'd0, bus0.q}, 32'b0101);
    step(1'b0, 1'b1, MODE_SHL, 4'hF, 4'h0, 4'hF, 1'b1);
    check("shl_1011", {28'd0, bus0.q}, 32'b1011);
    for (int n = 0; n < 3; n++) begin
      step(1'b0, 1'b0, MODE_UP, 4'hF, 4'hF, 4'h0, 1'b1);
      check("en0_hold", {28'd0, bus0.q}, 32'b1011);
      check("en0_tc", {31'd0, tc_seen}, 32'd0);
    end

    // Reset in the middle of a count, then resume from the reset value.
    step(1'b0, 1'b1, MODE_LOAD, 4'h0, 4'h0, 4'b0101, 1'b0);
    step(1'b1, 1'b1, MODE_UP, 4'h0, 4'h0, 4'h0, 1'b0);
    check("cnt_rst_rv0", {28'd0, bus0.q}, 32'b0000);
    check("cnt_rst_rv1", {28'd0, bus1.q}, 32'b1010);
    step(1'b0, 1'b1, MODE_UP, 4'h0, 4'h0, 4'h0, 1'b0);
    check("cnt_resume_rv0", {28'd0, bus0.q}, 32'b0001);
    check("cnt_resume_rv1", {28'd0, bus1.q}, 32'b1011);

    // Reserved encodings hold regardless of data inputs.
    for (int n = 0; n < 8; n++) begin
      step(1'b0, 1'b1, mode_t'(6 + (n % 2)), 4'($urandom), 4'($urandom),
           4'($urandom), 1'($urandom));
      check("reserved_hold", {28'd0, bus0.q}, 32'b0001);
    end

    // Random traffic against the model.
    for (int n = 0; n < 500; n++) begin
      step(($urandom_range(0, 31) == 0), ($urandom_range(0, 7) != 0),
           mode_t'($urandom_range(0, 7)), 4'($urandom), 4'($urandom),
           4'($urandom), 1'($urandom));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule : tb_jk_reg_bank
